// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer: NUM_SLOTS slots of FRAME_DEPTH words.
// Only CRC-confirmed frames reach the consumer; aborted, oversize and CRC-timeout frames are counted and dropped.
//
//  state      | meaning
//  W_IDLE     | waiting for the first beat of a frame (needs a free slot)
//  W_BURST    | storing beats into the current write slot
//  W_DISCARD  | frame overflowed its slot, sinking beats until tlast/abort
//  W_CRC      | frame stored, waiting up to CRC_TIMEOUT cycles for crc_valid
//  R_IDLE     | no committed frame being read
//  R_FETCH    | word 0 of rd_slot presented to the RAM
//  R_STREAM   | frame driven on the output stream
module rx_frame_buffer #(
   parameter int DATA_WIDTH  = 32,
   parameter int FRAME_DEPTH = 256,
   parameter int NUM_SLOTS   = 2,
   parameter int CRC_TIMEOUT = 15
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         data_valid,
   input  logic                         crc_valid,
   input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready,
   output logic [$clog2(NUM_SLOTS):0]   frames_pending,
   output logic [15:0]                  drop_count
);

   localparam int AW = $clog2(FRAME_DEPTH);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam int LW = AW + 1;
   localparam int PW = SW + 1;
   localparam int TW = 8;

   localparam logic [1:0] W_IDLE    = 2'd0;
   localparam logic [1:0] W_BURST   = 2'd1;
   localparam logic [1:0] W_DISCARD = 2'd2;
   localparam logic [1:0] W_CRC     = 2'd3;

   localparam logic [1:0] R_IDLE    = 2'd0;
   localparam logic [1:0] R_FETCH   = 2'd1;
   localparam logic [1:0] R_STREAM  = 2'd2;

   logic [DATA_WIDTH-1:0] mem [NUM_SLOTS*FRAME_DEPTH];
   logic [LW-1:0]         slot_len [NUM_SLOTS];

   logic [1:0]       wr_state;
   logic [AW-1:0]    wr_idx;
   logic [SW-1:0]    wr_slot;
   logic [LW-1:0]    wr_len;
   logic [TW-1:0]    crc_tmr;
   logic             wr_accept;
   logic             wr_we;
   logic [SW+AW-1:0] wr_addr;
   logic             commit;
   logic             drop_evt;

   logic [1:0]       rd_state;
   logic [AW-1:0]    rd_idx;
   logic [SW-1:0]    rd_slot;
   logic [LW-1:0]    rd_len;
   logic             rd_hs;
   logic             rd_done;
   logic             rd_en;
   logic             rd_go;
   logic             rd_last_next;
   logic             pend_seen;
   logic [SW+AW-1:0] rd_addr;

   always_comb begin
      s_axis_tready = 1'b0;
      if (!areset) begin
         case (wr_state)
            W_IDLE:    s_axis_tready = data_valid && (frames_pending < PW'(NUM_SLOTS));
            W_BURST:   s_axis_tready = data_valid;
            W_DISCARD: s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
         endcase
      end
   end

   assign wr_accept = s_axis_tvalid && s_axis_tready;
   assign commit    = (wr_state == W_CRC) && crc_valid;

   always_comb begin
      wr_we    = wr_accept && ((wr_state == W_IDLE) || (wr_state == W_BURST));
      wr_addr  = {wr_slot, wr_idx};
      if (wr_state == W_IDLE) wr_addr = {wr_slot, AW'(0)};
      drop_evt = 1'b0;
      case (wr_state)
         W_BURST:   drop_evt = !data_valid;
         W_DISCARD: drop_evt = !data_valid || (wr_accept && s_axis_tlast);
         W_CRC:     drop_evt = !crc_valid && (crc_tmr == '0);
         default:   drop_evt = 1'b0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_state <= W_IDLE;
         wr_idx   <= '0;
         wr_slot  <= '0;
         wr_len   <= '0;
         crc_tmr  <= '0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (wr_accept) begin
                  wr_idx <= AW'(1);
                  if (s_axis_tlast) begin
                     wr_len   <= LW'(1);
                     crc_tmr  <= TW'(CRC_TIMEOUT - 1);
                     wr_state <= W_CRC;
                  end else begin
                     wr_state <= W_BURST;
                  end
               end
            end
            W_BURST: begin
               if (!data_valid) begin
                  wr_state <= W_IDLE;
               end else if (wr_accept) begin
                  if (s_axis_tlast) begin
                     wr_len   <= {1'b0, wr_idx} + LW'(1);
                     crc_tmr  <= TW'(CRC_TIMEOUT - 1);
                     wr_state <= W_CRC;
                  end else if (wr_idx == AW'(FRAME_DEPTH - 1)) begin
                     wr_state <= W_DISCARD;
                  end else begin
                     wr_idx <= wr_idx + AW'(1);
                  end
               end
            end
            W_DISCARD: begin
               if (!data_valid || (wr_accept && s_axis_tlast)) wr_state <= W_IDLE;
            end
            W_CRC: begin
               // crc_valid wins over the terminal count on the final wait cycle
               if (crc_valid) begin
                  wr_slot  <= wr_slot + SW'(1);
                  wr_state <= W_IDLE;
               end else if (crc_tmr == '0) begin
                  wr_state <= W_IDLE;
               end else begin
                  crc_tmr <= crc_tmr - TW'(1);
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_we) mem[wr_addr] <= s_axis_tdata;
      if (commit) slot_len[wr_slot] <= wr_len;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         drop_count <= '0;
      end else if (drop_evt && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   assign rd_len       = slot_len[rd_slot];
   assign rd_hs        = m_axis_tvalid && m_axis_tready;
   assign rd_done      = rd_hs && m_axis_tlast;
   assign rd_last_next = (({1'b0, rd_idx} + LW'(2)) == rd_len);
   // A freshly committed frame is picked up one cycle after the count rises.
   assign rd_go        = (frames_pending != '0) && pend_seen;

   always_ff @(posedge aclk) begin
      if (areset) begin
         frames_pending <= '0;
         pend_seen      <= 1'b0;
      end else begin
         pend_seen <= (frames_pending != '0);
         if (commit && !rd_done) frames_pending <= frames_pending + PW'(1);
         else if (!commit && rd_done) frames_pending <= frames_pending - PW'(1);
      end
   end

   always_comb begin
      rd_en   = 1'b0;
      rd_addr = {rd_slot, rd_idx};
      case (rd_state)
         R_FETCH: begin
            rd_en   = 1'b1;
            rd_addr = {rd_slot, AW'(0)};
         end
         R_STREAM: begin
            rd_en   = 1'b1;
            rd_addr = {rd_slot, (rd_hs ? rd_idx + AW'(1) : rd_idx)};
         end
         default: rd_en = 1'b0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) m_axis_tdata <= '0;
      else if (rd_en) m_axis_tdata <= mem[rd_addr];
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_state      <= R_IDLE;
         rd_idx        <= '0;
         rd_slot       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               rd_idx <= '0;
               if (rd_go) rd_state <= R_FETCH;
            end
            R_FETCH: begin
               rd_idx        <= '0;
               m_axis_tvalid <= 1'b1;
               m_axis_tlast  <= (rd_len == LW'(1));
               rd_state      <= R_STREAM;
            end
            R_STREAM: begin
               if (rd_hs) begin
                  if (m_axis_tlast) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     rd_slot       <= rd_slot + SW'(1);
                     rd_state      <= R_IDLE;
                  end else begin
                     rd_idx       <= rd_idx + AW'(1);
                     m_axis_tlast <= rd_last_next;
                  end
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule
